// File: rtl/cw_fields_pkg.sv
// Control-word field map, PC-select encodings and status-bit indices
// shared by the control unit, the datapath and the fetch/status unit.
package cw_fields_pkg;

    localparam int CW_W = 98;

    localparam int NS_MSB    = 97;  localparam int NS_LSB    = 96;
    localparam int AS_MSB    = 95;  localparam int AS_LSB    = 95;
    localparam int DS_MSB    = 94;  localparam int DS_LSB    = 93;
    localparam int PS_MSB    = 92;  localparam int PS_LSB    = 91;
    localparam int PCSEL_MSB = 90;  localparam int PCSEL_LSB = 90;
    localparam int BSEL_MSB  = 89;  localparam int BSEL_LSB  = 89;
    localparam int IL_MSB    = 88;  localparam int IL_LSB    = 88;
    localparam int SL_MSB    = 87;  localparam int SL_LSB    = 87;
    localparam int FS_MSB    = 86;  localparam int FS_LSB    = 82;
    localparam int C0_MSB    = 81;  localparam int C0_LSB    = 81;
    localparam int MW_MSB    = 80;  localparam int MW_LSB    = 80;
    localparam int RW_MSB    = 79;  localparam int RW_LSB    = 79;
    localparam int DA_MSB    = 78;  localparam int DA_LSB    = 74;
    localparam int SA_MSB    = 73;  localparam int SA_LSB    = 69;
    localparam int SB_MSB    = 68;  localparam int SB_LSB    = 64;
    localparam int K_MSB     = 63;  localparam int K_LSB     = 0;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_REL  = 2'b10,
        PS_ABS  = 2'b11
    } ps_e;

    localparam int SR_V = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_Z = 0;

endpackage

// File: rtl/RegisterNbit.sv
// Generic N-bit register with synchronous active-high reset (R) and load enable (L).
module RegisterNbit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         R,
    input  logic         L,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock) begin
        if (R)
            Q <= '0;
        else if (L)
            Q <= D;
    end

endmodule

// File: rtl/pc_next.sv
// Combinational next-PC selection: hold, increment, K-relative branch or absolute jump.
module pc_next
    import cw_fields_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc,
    input  ps_e             ps,
    input  logic            pc_sel,
    input  logic [PC_W-1:0] k,
    input  logic [PC_W-1:0] reg_a_data,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] jump_target;

    always_comb begin
        // NOTE: default first so every path assigns next_pc and no latch is inferred.
        next_pc     = pc;
        jump_target = pc_sel ? reg_a_data : k;
        unique case (ps)
            PS_HOLD: next_pc = pc;
            PS_INC:  next_pc = pc + PC_W'(4);
            PS_REL:  next_pc = pc + (k << 2);
            PS_ABS:  next_pc = {jump_target[PC_W-1:2], 2'b00};
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_status_unit.sv
// Owns PC, IR and SR; decodes PS/PCSel/IL/SL/K from the control word and
// stalls fetch while instruction memory is not ready.
module fetch_status_unit
    import cw_fields_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [CW_W-1:0] control_word,
    input  logic [3:0]      alu_status,
    input  logic [PC_W-1:0] reg_a_data,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [31:0]     instruction,
    output logic [3:0]      status,
    output logic            stall
);

    ps_e             ps;
    logic            pc_sel;
    logic            il;
    logic            sl;
    logic [PC_W-1:0] k;
    logic [PC_W-1:0] next_pc;

    assign ps     = ps_e'(control_word[PS_MSB:PS_LSB]);
    assign pc_sel = control_word[PCSEL_MSB];
    assign il     = control_word[IL_MSB];
    assign sl     = control_word[SL_MSB];
    assign k      = control_word[K_LSB +: PC_W];

    // Fields owned by the datapath and control unit; carried here untouched.
    logic unused_fields;
    assign unused_fields = ^{control_word[NS_MSB:BSEL_LSB], control_word[FS_MSB:SB_LSB],
                             control_word[K_MSB:K_LSB]};

    assign stall    = il & ~mem_ready;
    assign pc_plus4 = pc + PC_W'(4);

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc         (pc),
        .ps         (ps),
        .pc_sel     (pc_sel),
        .k          (k),
        .reg_a_data (reg_a_data),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clock) begin
        if (reset)
            pc <= RESET_PC;
        else if (!stall)
            pc <= next_pc;
    end

    // IR reads the pre-update pc address; it commits on the same edge as the PC.
    RegisterNbit #(.N(32)) u_ir (
        .clock (clock),
        .R     (reset),
        .L     (il & mem_ready),
        .D     (mem_rdata),
        .Q     (instruction)
    );

    RegisterNbit #(.N(4)) u_sr (
        .clock (clock),
        .R     (reset),
        .L     (sl & ~stall),
        .D     (alu_status),
        .Q     (status)
    );

    a_ctrl_known: assert property (@(posedge clock) disable iff (reset)
        !$isunknown({control_word[PS_MSB:PS_LSB], il, sl}));

endmodule

// File: tb/tb_fetch_status_unit.sv
// Self-checking bench for fetch_status_unit: directed vector table, a few
// hand-written corner sequences and randomized traffic against a reference model.
module tb_fetch_status_unit;
    import cw_fields_pkg::*;

    localparam int PC_W = 64;

    logic            clock = 1'b0;
    logic            reset;
    logic [CW_W-1:0] control_word;
    logic [3:0]      alu_status;
    logic [PC_W-1:0] reg_a_data;
    logic [31:0]     mem_rdata;
    logic            mem_ready;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic [31:0]     instruction;
    logic [3:0]      status;
    logic            stall;

    fetch_status_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clock        (clock),
        .reset        (reset),
        .control_word (control_word),
        .alu_status   (alu_status),
        .reg_a_data   (reg_a_data),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instruction  (instruction),
        .status       (status),
        .stall        (stall)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state, updated from the behavioural rules.
    logic [63:0] m_pc, m_ir, m_sr;

    typedef struct {
        logic        rst;
        logic [1:0]  ps;
        logic        pcsel;
        logic        il;
        logic        sl;
        logic [63:0] k;
        logic [3:0]  alu;
        logic [63:0] rega;
        logic [31:0] rdata;
        logic        rdy;
        logic        exp_stall;
        logic [63:0] exp_pc;
        logic [31:0] exp_ir;
        logic [3:0]  exp_sr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rst, input logic [1:0] ps, input logic pcsel,
                           input logic il, input logic sl, input logic [63:0] k,
                           input logic [3:0] alu, input logic [63:0] rega,
                           input logic [31:0] rdata, input logic rdy, input logic es,
                           input logic [63:0] epc, input logic [31:0] eir,
                           input logic [3:0] esr);
        vec_t v;
        v.rst = rst; v.ps = ps; v.pcsel = pcsel; v.il = il; v.sl = sl; v.k = k;
        v.alu = alu; v.rega = rega; v.rdata = rdata; v.rdy = rdy;
        v.exp_stall = es; v.exp_pc = epc; v.exp_ir = eir; v.exp_sr = esr;
        vecs.push_back(v);
    endtask

    // Ignored fields carry random junk so decoding of only PS/PCSel/IL/SL/K is exercised.
    function automatic logic [CW_W-1:0] make_cw(input logic [1:0] ps, input logic pcsel,
                                                 input logic il, input logic sl,
                                                 input logic [63:0] k);
        logic [127:0]    junk;
        logic [CW_W-1:0] cw;
        junk = {$urandom, $urandom, $urandom, $urandom};
        cw = junk[CW_W-1:0];
        cw[PS_MSB:PS_LSB] = ps;
        cw[PCSEL_MSB]     = pcsel;
        cw[IL_MSB]        = il;
        cw[SL_MSB]        = sl;
        cw[K_MSB:K_LSB]   = k;
        return cw;
    endfunction

    function automatic void model_step(input vec_t v);
        logic [63:0] target;
        if (v.rst) begin
            m_pc = 64'd0; m_ir = 64'd0; m_sr = 64'd0;
        end else if (!(v.il && !v.rdy)) begin
            if (v.il) m_ir = {32'd0, v.rdata};
            if (v.sl) m_sr = {60'd0, v.alu};
            case (v.ps)
                2'd1: m_pc = m_pc + 64'd4;
                2'd2: m_pc = m_pc + v.k * 64'd4;
                2'd3: begin
                    target = v.pcsel ? v.rega : v.k;
                    m_pc = target - (target % 64'd4);
                end
                default: ;
            endcase
        end
    endfunction

    // Drive one cycle at negedge, check combinational outputs, then registered outputs.
    task automatic run_cycle(input vec_t v, input logic use_table, input string tag);
        @(negedge clock);
        reset        = v.rst;
        control_word = make_cw(v.ps, v.pcsel, v.il, v.sl, v.k);
        alu_status   = v.alu;
        reg_a_data   = v.rega;
        mem_rdata    = v.rdata;
        mem_ready    = v.rdy;
        #1;
        check({tag, ".stall"}, {63'd0, stall}, {63'd0, v.il & ~v.rdy});
        if (!v.rst) check({tag, ".pc_plus4"}, pc_plus4, m_pc + 64'd4);
        model_step(v);
        @(posedge clock);
        #1;
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".ir"}, {32'd0, instruction}, m_ir);
        check({tag, ".sr"}, {60'd0, status}, m_sr);
        if (use_table) begin
            check({tag, ".tbl_stall"}, {63'd0, v.exp_stall}, {63'd0, v.il & ~v.rdy});
            check({tag, ".tbl_pc"}, pc, v.exp_pc);
            check({tag, ".tbl_ir"}, {32'd0, instruction}, {32'd0, v.exp_ir});
            check({tag, ".tbl_sr"}, {60'd0, status}, {60'd0, v.exp_sr});
        end
    endtask

    initial begin
        vec_t v;
        m_pc = '0; m_ir = '0; m_sr = '0;
        reset = 1'b1; control_word = '0; alu_status = '0; reg_a_data = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        //       rst ps    sel il  sl  k                      alu    rega                   rdata          rdy st  pc                     ir             sr
        add_vec(1, 2'd0, 0, 0, 0, 64'd0,                 4'h0, 64'd0,                 32'h0,         1, 0, 64'd0,                 32'h0,         4'h0);
        add_vec(0, 2'd0, 0, 0, 0, 64'd0,                 4'h0, 64'd0,                 32'h0,         1, 0, 64'd0,                 32'h0,         4'h0);
        add_vec(0, 2'd0, 0, 0, 0, 64'd0,                 4'h0, 64'd0,                 32'h0,         0, 0, 64'd0,                 32'h0,         4'h0);
        add_vec(0, 2'd0, 0, 0, 0, 64'd0,                 4'h0, 64'd0,                 32'h0,         1, 0, 64'd0,                 32'h0,         4'h0);
        add_vec(0, 2'd1, 0, 1, 0, 64'd0,                 4'h0, 64'd0,                 32'hDEADBEEF,  1, 0, 64'd4,                 32'hDEADBEEF,  4'h0);
        add_vec(0, 2'd1, 0, 1, 1, 64'd0,                 4'h7, 64'd0,                 32'h12345678,  0, 1, 64'd4,                 32'hDEADBEEF,  4'h0);
        add_vec(0, 2'd1, 0, 1, 0, 64'd0,                 4'h0, 64'd0,                 32'h12345678,  0, 1, 64'd4,                 32'hDEADBEEF,  4'h0);
        add_vec(0, 2'd1, 0, 1, 0, 64'd0,                 4'h0, 64'd0,                 32'h12345678,  0, 1, 64'd4,                 32'hDEADBEEF,  4'h0);
        add_vec(0, 2'd1, 0, 1, 0, 64'd0,                 4'h0, 64'd0,                 32'hCAFEF00D,  1, 0, 64'd8,                 32'hCAFEF00D,  4'h0);
        add_vec(0, 2'd3, 0, 0, 0, 64'h100,               4'h0, 64'd0,                 32'h0,         1, 0, 64'h100,               32'hCAFEF00D,  4'h0);
        add_vec(0, 2'd2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'h0, 64'd0,               32'h0,         1, 0, 64'hF8,                32'hCAFEF00D,  4'h0);
        add_vec(0, 2'd3, 1, 0, 0, 64'd0,                 4'h0, 64'h2003,              32'h0,         1, 0, 64'h2000,              32'hCAFEF00D,  4'h0);
        add_vec(0, 2'd3, 0, 0, 0, 64'h40,                4'h0, 64'h2003,              32'h0,         1, 0, 64'h40,                32'hCAFEF00D,  4'h0);
        add_vec(0, 2'd0, 0, 0, 1, 64'd0,                 4'hA, 64'd0,                 32'h0,         1, 0, 64'h40,                32'hCAFEF00D,  4'hA);
        add_vec(0, 2'd0, 0, 0, 0, 64'd0,                 4'h5, 64'd0,                 32'h0,         1, 0, 64'h40,                32'hCAFEF00D,  4'hA);
        add_vec(0, 2'd3, 1, 0, 0, 64'd0,                 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0,       1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFEF00D, 4'hA);
        add_vec(0, 2'd1, 0, 0, 0, 64'd0,                 4'h0, 64'd0,                 32'h0,         1, 0, 64'd0,                 32'hCAFEF00D,  4'hA);
        add_vec(0, 2'd2, 0, 1, 1, 64'd5,                 4'hF, 64'd0,                 32'h11111111,  0, 1, 64'd0,                 32'hCAFEF00D,  4'hA);
        add_vec(0, 2'd2, 0, 1, 1, 64'd5,                 4'hF, 64'd0,                 32'h22222222,  1, 0, 64'd20,                32'h22222222,  4'hF);
        add_vec(1, 2'd2, 0, 1, 1, 64'd5,                 4'hF, 64'd0,                 32'h33333333,  0, 1, 64'd0,                 32'h0,         4'h0);
        add_vec(0, 2'd0, 0, 1, 0, 64'd0,                 4'h0, 64'd0,                 32'h44444444,  0, 1, 64'd0,                 32'h0,         4'h0);

        foreach (vecs[i]) run_cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // Stall during a reset-priority setup: stall, then reset with IL/SL/PS active.
        v = vecs[0];
        v.rst = 0; v.ps = 2'd1; v.il = 1; v.sl = 0; v.rdata = 32'h5A5A5A5A; v.rdy = 1;
        run_cycle(v, 1'b0, "seq_fetch");
        v.rdy = 0; v.sl = 1; v.ps = 2'd2; v.k = 64'h10; v.alu = 4'h9;
        run_cycle(v, 1'b0, "seq_stall");
        v.rst = 1;
        run_cycle(v, 1'b0, "seq_rst_stall");
        check("seq_rst_pc", pc, 64'd0);

        // Relative branch wrapping below zero.
        v.rst = 0; v.il = 0; v.sl = 0; v.ps = 2'd2; v.k = 64'hFFFF_FFFF_FFFF_FFFF;
        run_cycle(v, 1'b0, "seq_rel_wrap");
        check("seq_rel_wrap_abs", pc, 64'hFFFF_FFFF_FFFF_FFFC);

        for (int n = 0; n < 400; n++) begin
            v.rst   = ($urandom_range(0, 31) == 0);
            v.ps    = 2'($urandom_range(0, 3));
            v.pcsel = 1'($urandom_range(0, 1));
            v.il    = 1'($urandom_range(0, 1));
            v.sl    = 1'($urandom_range(0, 1));
            v.k     = {$urandom, $urandom};
            v.alu   = 4'($urandom_range(0, 15));
            v.rega  = {$urandom, $urandom};
            v.rdata = $urandom;
            v.rdy   = ($urandom_range(0, 3) != 0);
            run_cycle(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_status_unit.md
Name: fetch_status_unit

Overview:
- Consumer of the 98-bit control word. Owns the program counter (PC), the instruction register (IR) and the 4-bit status register (SR).
- Feeds `instruction` and `status` back to the control unit, closing the fetch/execute loop.
- Decodes only the fields it acts on (PS, PCSel, IL, SL, K). All other fields pass to the datapath untouched.
- Adds a memory-ready stall so fetch tolerates slow instruction memory.

Parameters:
- PC_W, 64: PC width; matches K field width.
- RESET_PC, 0: PC value after reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears state on the next rising edge
- control_word  input  98  control word from the control unit; fields decoded below
- alu_status  input  4  {V,C,N,Z} from the ALU in the current cycle
- reg_a_data  input  PC_W  register-file A-bus value (indirect jump target)
- mem_rdata  input  32  instruction memory read data at address `pc`
- mem_ready  input  1  mem_rdata valid this cycle
- pc  output  PC_W  current PC; instruction memory address
- pc_plus4  output  PC_W  pc+4, modulo 2^PC_W (link value for datapath)
- instruction  output  32  IR contents
- status  output  4  SR contents {V,C,N,Z}
- stall  output  1  fetch waiting on memory; control unit must hold its state register

Behaviour:
- Field map (MSB→LSB):
  - NS[97:96], AS[95], DS[94:93], PS[92:91], PCSel[90], BSel[89]
  - IL[88], SL[87], FS[86:82], C0[81], MW[80], RW[79]
  - DA[78:74], SA[73:69], SB[68:64], K[63:0]
- Reset (sync): pc=RESET_PC, instruction=32'h0, status=4'h0; stall is combinational from inputs. Reset wins over every other event in the same cycle.
- stall = IL & ~mem_ready (combinational, zero latency).
- While stall=1, PC, IR and SR all hold, regardless of PS/SL.
- IR: when IL=1 and mem_ready=1, instruction <= mem_rdata at the edge. Visible the cycle after the load.
- SR: when SL=1 and stall=0, status <= alu_status. Otherwise hold.
- PC update (stall=0), one-cycle latency, by PS:
  - 00: hold.
  - 01: pc <= pc+4.
  - 10: relative branch; pc <= pc + (K<<2). Shift is within PC_W bits; the two K bits shifted out are discarded.
  - 11: absolute jump; pc <= PCSel ? reg_a_data : K[PC_W-1:0]. Low 2 bits forced to 0.
- All PC arithmetic is unsigned modulo 2^PC_W. Wrap-around is silent; no trap.
- Simultaneous IL and PS≠00 in one cycle:
  - IR loads from the pre-update pc address.
  - PC update uses the pre-update pc.
  - Both commit on the same edge.
- Fields ignored by this block (AS, DS, BSel, FS, C0, MW, RW, DA, SA, SB, NS) may be X.
- PS, IL and SL must be 0/1 every non-reset cycle. Simulation-only assertion flags X on them.
- PCSel must be defined when PS=11. K must be defined when PS ∈ {10, 11}.
- Reset while stalled: stall state is not stored. After reset, stall depends only on the current IL/mem_ready.

Decomposition:
- Shared package `cw_fields_pkg`:
  - bit-position constants for every control-word field (MSB/LSB pairs above)
  - PS encodings: PS_HOLD=2'b00, PS_INC=2'b01, PS_REL=2'b10, PS_ABS=2'b11
  - SR bit indices V=3, C=2, N=1, Z=0
  - CW_W=98
- Control unit and datapath import the same package.
- One natural sub-module: `pc_next` (combinational next-PC mux/adder given pc, PS, PCSel, K, reg_a_data).
- IR and SR use the existing RegisterNbit (N=32 and N=4), with L = load enable and R = reset.

Test Plan:
- Reset then idle: reset=1 one cycle, then PS=00/IL=0/SL=0 → pc=0, instruction=0, status=0, stall=0; values held 3 cycles.
- Fetch with ready: IL=1, PS=01, mem_ready=1, mem_rdata=32'hDEADBEEF at pc=0 → next cycle instruction=DEADBEEF, pc=4.
- Fetch stall: IL=1, PS=01, mem_ready=0 for 3 cycles, then 1 → stall=1 for those 3 cycles with pc=0 and IR unchanged; on the ready cycle stall=0, then pc=4 and IR loaded.
- Branches:
  - pc=0x100, PS=10, K=-2 → pc=0xF8.
  - Then PS=11, PCSel=1, reg_a_data=0x2003 → pc=0x2000.
  - Then PS=11, PCSel=0, K=0x40 → pc=0x40.
- Status load and wrap:
  - SL=1, alu_status=4'b1010 → status=1010; SL=0 next cycle with alu_status=0101 → status stays 1010.
  - pc=2^64-4, PS=01 → pc=0.
- Reset priority: during a stall with SL=1, IL=1, PS=10, assert reset → next cycle pc=RESET_PC, IR=0, SR=0.
